mat_mult_seq: RTL and testbench
===============================

// Module: mat_mult_seq
// PURPOSE
//  Parametrised sequential NxN unsigned matrix multiplier, Res = A x B, with valid/ready on input and output.
//  Successor of the fixed 2x2 combinational multiplier. N*N MAC lanes run in parallel and sweep k over N cycles.
//  Sits between the matrix loader and the result writer in the matrix datapath.
// PARAMETERS
//  N     2            matrix dimension (N>=1)
//  DW    8            element width, unsigned
//  ACCW  2*DW+$clog2(N)+1   accumulator/result element width; no overflow possible
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  reset      in   1          synchronous, active-high
//  A          in   N*N*DW     row-major; A[0][0] in MSBs, A[N-1][N-1] in LSBs
//  B          in   N*N*DW     same packing as A
//  in_valid   in   1          A/B valid
//  in_ready   out  1          block can accept A/B
//  Res        out  N*N*ACCW   row-major, Res[0][0] in MSBs
//  out_valid  out  1          Res valid
//  out_ready  in   1          consumer accepts Res
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, in_ready=1, out_valid=0, Res=0, k=0, accumulators=0.
//    Reset at any point, including mid-COMPUTE or while DONE is stalled, aborts the operation; the result is discarded.
//  - FSM IDLE -> COMPUTE -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&&in_ready, register A and B, clear accumulators, set k=0, go to COMPUTE.
//    COMPUTE: in_ready=0. Each cycle acc[i][j] += A[i][k]*B[k][j] for all i,j, then k++.
//      On k==N-1: load Res from the final sums (acc + last product) and go to DONE.
//    DONE: out_valid=1, Res held stable. On out_ready, clear out_valid and go to IDLE.
//  - Latency: handshake edge at cycle 0; out_valid high in cycle N+1. Min initiation interval N+2 cycles.
//  - in_ready is a registered state decode and does not depend on out_ready. No accept in COMPUTE or DONE.
//  - out_valid, once high, stays high and Res is unchanged until out_ready is sampled high.
//  - in_valid while in_ready=0 is ignored. A/B inputs need only be stable on the handshake cycle.
//  - Arithmetic: unsigned; products are 2*DW bits, zero-extended to ACCW; no saturation or wrap.
//  - N=1: COMPUTE lasts one cycle and Res = A*B.
//  - Res keeps its last value after the DONE handshake until the next load.
// STRUCTURE
//  - Package mat_pkg: state typedef (IDLE/COMPUTE/DONE), function acc_width(DW,N), packing index helpers idx(i,j,N).
//  - Sub-module mac_lane (DW, ACCW): clear, en, a, b -> acc register.
//    Instantiated N*N times in a generate loop; the top level holds the FSM, k counter, operand registers and Res.
// TESTING
//  1. N=2, DW=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> out_valid in cycle 3, Res=[[19,22],[43,50]].
//  2. N=2: all elements 255 -> every Res element 130050 (ACCW=18), no overflow.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     -> Res/out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE the next cycle.
//  4. Back-to-back: two pairs (test 1 operands, then identity x B) with in_valid held.
//     -> second accept 4 cycles after the first, second Res=[[5,6],[7,8]].
//  5. Reset mid-COMPUTE (k=1) -> next cycle in_ready=1, out_valid=0, Res=0. A new operation completes correctly.
//  6. N=3, DW=4: A=I3, B=[[1..9]] -> Res=B. out_valid in cycle 4.
//  7. N=1: A=7, B=9 -> Res=63 in cycle 2.

Source files
------------

// File: rtl/mat_mult_seq_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
package mat_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   // Result element width large enough that N products of two DW-bit values never overflow.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
      return 2 * dw + $clog2(n) + 1;
   endfunction

   // Element position of [i][j] in a row-major packed vector, with [0][0] in the MSBs.
   function automatic int unsigned idx(input int unsigned i, input int unsigned j,
                                       input int unsigned n);
      return n * n - 1 - (i * n + j);
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: acc += a*b when enabled, cleared on demand.
module mac_lane #(
   parameter int unsigned DW   = 8,
   parameter int unsigned ACCW = 18
) (
   input  logic            clk,
   input  logic            clear,
   input  logic            en,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc_next
);

   logic [ACCW-1:0] acc;
   logic [2*DW-1:0] prod;

   // Unsigned product zero-extended into the accumulator width, added to the running sum.
   always_comb begin
      prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      acc_next = acc + {{(ACCW-2*DW){1'b0}}, prod};
   end

   // Accumulator register; clear has priority over accumulate.
   always_ff @(posedge clk) begin
      if (clear)
         acc <= '0;
      else if (en)
         acc <= acc_next;
   end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN unsigned matrix multiplier: N*N MAC lanes sweep k over N cycles.
module mat_mult_seq
   import mat_pkg::*;
#(
   parameter int unsigned N    = 2,
   parameter int unsigned DW   = 8,
   parameter int unsigned ACCW = acc_width(DW, N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*N*DW-1:0]    A,
   input  logic [N*N*DW-1:0]    B,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [N*N*ACCW-1:0]  Res,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned NE = N * N;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   state_t             state;
   logic [KW-1:0]      k;
   logic [NE*DW-1:0]   a_r;
   logic [NE*DW-1:0]   b_r;
   logic [ACCW-1:0]    lane_sum [NE];
   logic               lane_clr;
   logic               lane_en;
   logic               last;

   // Lane control: clear on reset or on accept, accumulate only while computing.
   always_comb begin
      lane_clr = reset || (state == IDLE && in_valid);
      lane_en  = (state == COMPUTE);
      last     = (k == KW'(N - 1));
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [DW-1:0] a_sel;
         logic [DW-1:0] b_sel;

         // Operand mux: picks A[i][k] and B[k][j] for the current sweep step.
         always_comb begin
            a_sel = '0;
            b_sel = '0;
            for (int unsigned kk = 0; kk < N; kk++) begin
               if (k == KW'(kk)) begin
                  a_sel = a_r[idx(gi, kk, N)*DW +: DW];
                  b_sel = b_r[idx(kk, gj, N)*DW +: DW];
               end
            end
         end

         mac_lane #(
            .DW   (DW),
            .ACCW (ACCW)
         ) u_lane (
            .clk      (clk),
            .clear    (lane_clr),
            .en       (lane_en),
            .a        (a_sel),
            .b        (b_sel),
            .acc_next (lane_sum[idx(gi, gj, N)])
         );
      end
   end

   // Control FSM with registered handshake outputs; Res loads from the lanes' final sums.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Res       <= '0;
         k         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= A;
                  b_r      <= B;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (last) begin
                  for (int unsigned e = 0; e < NE; e++)
                     Res[e*ACCW +: ACCW] <= lane_sum[e];
                  k         <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: N=2/DW=8 with a scoreboard, plus N=3 and N=1 instances.
module tb_mat_mult_seq;

   logic clk;
   logic reset;

   // N=2, DW=8, ACCW=18
   logic [31:0]  A2, B2;
   logic         in_valid2, in_ready2, out_valid2, out_ready2;
   logic [71:0]  Res2;
   // N=3, DW=4, ACCW=11
   logic [35:0]  A3, B3;
   logic         in_valid3, in_ready3, out_valid3, out_ready3;
   logic [98:0]  Res3;
   // N=1, DW=8, ACCW=17
   logic [7:0]   A1, B1;
   logic         in_valid1, in_ready1, out_valid1, out_ready1;
   logic [16:0]  Res1;

   int unsigned  total;
   int unsigned  passed;
   logic [127:0] q[$];

   mat_mult_seq #(.N(2), .DW(8)) dut2 (
      .clk(clk), .reset(reset), .A(A2), .B(B2), .in_valid(in_valid2), .in_ready(in_ready2),
      .Res(Res2), .out_valid(out_valid2), .out_ready(out_ready2));

   mat_mult_seq #(.N(3), .DW(4)) dut3 (
      .clk(clk), .reset(reset), .A(A3), .B(B3), .in_valid(in_valid3), .in_ready(in_ready3),
      .Res(Res3), .out_valid(out_valid3), .out_ready(out_ready3));

   mat_mult_seq #(.N(1), .DW(8)) dut1 (
      .clk(clk), .reset(reset), .A(A1), .B(B1), .in_valid(in_valid1), .in_ready(in_ready1),
      .Res(Res1), .out_valid(out_valid1), .out_ready(out_ready1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Row-major pack, first element ends in the MSBs.
   function automatic logic [127:0] pk(input int n, input int w, input int m[9]);
      logic [127:0] r;
      r = '0;
      for (int e = 0; e < n * n; e++)
         r = (r << w) | 128'(m[e]);
      return r;
   endfunction

   function automatic logic [127:0] matmul(input int n, input int w, input int a[9], input int b[9]);
      int s[9];
      for (int e = 0; e < 9; e++) s[e] = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            for (int kk = 0; kk < n; kk++)
               s[i*n+j] += a[i*n+kk] * b[kk*n+j];
      return pk(n, w, s);
   endfunction

   task automatic send2(input int a[9], input int b[9], input bit expect_out);
      A2 = 32'(pk(2, 8, a));
      B2 = 32'(pk(2, 8, b));
      in_valid2 = 1'b1;
      if (expect_out) q.push_back(matmul(2, 18, a, b));
      tick();
      in_valid2 = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 128'(q.size()), 0);
   endtask

   // Scoreboard consumer for the N=2 instance.
   always @(negedge clk) begin
      if (!reset && out_valid2 && out_ready2) begin
         if (q.size() == 0) chk("sb_unexpected_out", 128'(out_valid2), 0);
         else chk("sb_res", 128'(Res2), q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ma[9], mb[9], mf[9], mi[9], mc[9], md[9], i3[9], b9[9], r1[9], r2[9];
      int cnt;
      logic [127:0] exp;

      ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
      mf = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
      mi = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
      mc = '{2, 0, 1, 3, 0, 0, 0, 0, 0};
      md = '{4, 5, 6, 7, 0, 0, 0, 0, 0};
      i3 = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      b9 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      r1 = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
      r2 = '{130050, 130050, 130050, 130050, 0, 0, 0, 0, 0};

      total = 0; passed = 0;
      reset = 1'b1;
      A2 = '0; B2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
      A3 = '0; B3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
      A1 = '0; B1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
      repeat (2) tick();
      reset = 1'b0;

      // Reset state
      chk("rst_in_ready2", 128'(in_ready2), 1);
      chk("rst_out_valid2", 128'(out_valid2), 0);
      chk("rst_res2", 128'(Res2), 0);
      chk("rst_in_ready3", 128'(in_ready3), 1);
      chk("rst_in_ready1", 128'(in_ready1), 1);

      // Test 1: basic 2x2, latency
      send2(ma, mb, 1'b1);
      chk("t1_busy", 128'(in_ready2), 0);
      chk("t1_ov_c1", 128'(out_valid2), 0);
      tick();
      chk("t1_ov_c2", 128'(out_valid2), 0);
      tick();
      chk("t1_ov_c3", 128'(out_valid2), 1);
      chk("t1_res", 128'(Res2), pk(2, 18, r1));
      tick();
      chk("t1_idle_ready", 128'(in_ready2), 1);
      chk("t1_idle_ov", 128'(out_valid2), 0);
      chk("t1_res_hold", 128'(Res2), pk(2, 18, r1));

      // Test 2: maximum operands, no overflow
      send2(mf, mf, 1'b1);
      tick(); tick();
      chk("t2_ov", 128'(out_valid2), 1);
      chk("t2_res", 128'(Res2), pk(2, 18, r2));
      tick();

      // Test 3: backpressure in DONE, new in_valid ignored
      out_ready2 = 1'b0;
      send2(mc, md, 1'b1);
      tick(); tick();
      exp = matmul(2, 18, mc, md);
      A2 = 32'(pk(2, 8, mf));
      B2 = 32'(pk(2, 8, mf));
      in_valid2 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("t3_ov_hold", 128'(out_valid2), 1);
         chk("t3_in_ready", 128'(in_ready2), 0);
         chk("t3_res_hold", 128'(Res2), exp);
         tick();
      end
      in_valid2 = 1'b0;
      out_ready2 = 1'b1;
      tick();
      chk("t3_back_idle", 128'(in_ready2), 1);
      chk("t3_ov_clear", 128'(out_valid2), 0);

      // Test 4: back-to-back with in_valid held
      A2 = 32'(pk(2, 8, ma));
      B2 = 32'(pk(2, 8, mb));
      in_valid2 = 1'b1;
      q.push_back(matmul(2, 18, ma, mb));
      tick();
      A2 = 32'(pk(2, 8, mi));
      B2 = 32'(pk(2, 8, mb));
      q.push_back(pk(2, 18, mb));
      cnt = 0;
      while (cnt < 20) begin
         tick();
         cnt++;
         if (in_ready2) break;
      end
      chk("t4_accept_gap", 128'(cnt + 1), 4);
      tick();
      in_valid2 = 1'b0;
      chk("t4_second_accepted", 128'(in_ready2), 0);
      drain("t4_drained");
      tick();

      // Test 5: reset mid-COMPUTE at k=1
      send2(mf, mf, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("t5_in_ready", 128'(in_ready2), 1);
      chk("t5_out_valid", 128'(out_valid2), 0);
      chk("t5_res_zero", 128'(Res2), 0);
      reset = 1'b0;
      send2(ma, mb, 1'b1);
      drain("t5_drained");

      // Test 6: N=3, identity x B
      A3 = 36'(pk(3, 4, i3));
      B3 = 36'(pk(3, 4, b9));
      in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      cnt = 0;
      while (cnt < 20) begin
         tick();
         cnt++;
         if (out_valid3) break;
      end
      chk("t6_latency", 128'(cnt), 3);
      chk("t6_res", 128'(Res3), pk(3, 11, b9));

      // Test 7: N=1
      A1 = 8'd7;
      B1 = 8'd9;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      cnt = 0;
      while (cnt < 20) begin
         tick();
         cnt++;
         if (out_valid1) break;
      end
      chk("t7_latency", 128'(cnt), 1);
      chk("t7_res", 128'(Res1), 63);

      tick();
      chk("sb_empty_end", 128'(q.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
